// File: rtl/heartbeat_gen.sv
// Liveness supervisor on the watchdog side. Gathers per-subsystem alive strobes
// and emits a heartbeat when all of them check in within a window. On a watchdog
// force_reset it holds a timed system reset, then re-arms through a grace period.
module heartbeat_gen #(
  parameter int unsigned NUM_SRC       = 3,
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned GRACE_CYCLES  = 64,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [NUM_SRC-1:0] src_alive,
  input  logic               wd_force_reset,
  output logic               heartbeat,
  output logic               wd_enable,
  output logic               sys_reset,
  output logic [1:0]         state,
  output logic [NUM_SRC-1:0] missed_src,
  output logic [7:0]         reset_count
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrace   = 2'd1,
    StMonitor = 2'd2,
    StRecover = 2'd3
  } state_e;

  // Terminal counter values; the counter only ever compares on equality.
  localparam logic [CNT_W-1:0] GraceLast  = CNT_W'(GRACE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WindowLast = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] seen_q, seen_d;
  logic [NUM_SRC-1:0] missed_q, missed_d;
  logic [7:0]         rcnt_q, rcnt_d;
  logic               hb_q, hb_d;
  logic               en_q, en_d;
  logic               sys_q, sys_d;

  logic [NUM_SRC-1:0] next_seen;
  logic               complete;

  assign next_seen = seen_q | src_alive;
  // A completion landing on a heartbeat cycle is deferred by one cycle (the
  // set stays latched in seen_q) so heartbeat is never high twice in a row.
  assign complete  = (&next_seen) && !hb_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    missed_d = missed_q;
    rcnt_d   = rcnt_q;
    hb_d     = 1'b0;
    sys_d    = 1'b0;

    if (state_q != StIdle && !arm) begin
      state_d = StIdle;
      cnt_d   = '0;
      seen_d  = '0;
    end else if ((state_q == StGrace || state_q == StMonitor) && wd_force_reset) begin
      state_d = StRecover;
      cnt_d   = '0;
      seen_d  = '0;
      sys_d   = 1'b1;
      if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_d = StGrace;
            cnt_d   = '0;
            hb_d    = 1'b1;
          end
        end
        StGrace: begin
          if (cnt_q == GraceLast) begin
            state_d = StMonitor;
            cnt_d   = '0;
            seen_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StMonitor: begin
          if (complete) begin
            hb_d   = 1'b1;
            seen_d = '0;
            cnt_d  = '0;
          end else if (cnt_q == WindowLast) begin
            missed_d = ~next_seen;
            seen_d   = '0;
            cnt_d    = '0;
          end else begin
            seen_d = next_seen;
            cnt_d  = cnt_q + 1'b1;
          end
        end
        StRecover: begin
          if (cnt_q == HoldLast) begin
            state_d = StGrace;
            cnt_d   = '0;
            hb_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            sys_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign en_d = (state_d != StIdle);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      seen_q   <= '0;
      missed_q <= '0;
      rcnt_q   <= '0;
      hb_q     <= 1'b0;
      en_q     <= 1'b0;
      sys_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      missed_q <= missed_d;
      rcnt_q   <= rcnt_d;
      hb_q     <= hb_d;
      en_q     <= en_d;
      sys_q    <= sys_d;
    end
  end

  assign heartbeat   = hb_q;
  assign wd_enable   = en_q;
  assign sys_reset   = sys_q;
  assign state       = state_q;
  assign missed_src  = missed_q;
  assign reset_count = rcnt_q;

endmodule

// File: tb/tb_heartbeat_gen.sv
// Directed bench for heartbeat_gen with a small window/grace/hold configuration.
module tb_heartbeat_gen;

  localparam int unsigned NumSrc = 3;

  logic              clk = 1'b0;
  logic              rst, arm, wd_force_reset;
  logic [NumSrc-1:0] src_alive;
  logic              heartbeat, wd_enable, sys_reset;
  logic [1:0]        state;
  logic [NumSrc-1:0] missed_src;
  logic [7:0]        reset_count;

  int checks   = 0;
  int failures = 0;

  heartbeat_gen #(
    .NUM_SRC      (NumSrc),
    .WINDOW_CYCLES(8),
    .GRACE_CYCLES (4),
    .HOLD_CYCLES  (3),
    .CNT_W        (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .src_alive     (src_alive),
    .wd_force_reset(wd_force_reset),
    .heartbeat     (heartbeat),
    .wd_enable     (wd_enable),
    .sys_reset     (sys_reset),
    .state         (state),
    .missed_src    (missed_src),
    .reset_count   (reset_count)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; wd_force_reset = 1'b0; src_alive = '0;
    tick();
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_hb", 32'(heartbeat), 0);
    chk("rst_en", 32'(wd_enable), 0);
    chk("rst_sys", 32'(sys_reset), 0);
    chk("rst_missed", 32'(missed_src), 0);
    chk("rst_count", 32'(reset_count), 0);

    // 1. Arm and grace
    rst = 1'b0; arm = 1'b1;
    tick();
    chk("grace_state", 32'(state), 1);
    chk("grace_hb_first", 32'(heartbeat), 1);
    chk("grace_en", 32'(wd_enable), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("grace_hb_low", 32'(heartbeat), 0);
      chk("grace_state_hold", 32'(state), 1);
    end
    tick();
    chk("monitor_entry", 32'(state), 2);
    chk("monitor_en", 32'(wd_enable), 1);

    // 2. Normal heartbeat: window cycle 0 now
    tick(); src_alive = 3'b001;        // wc1
    tick(); src_alive = 3'b010;        // wc2
    tick(); src_alive = 3'b000;        // wc3
    chk("norm_hb_wc3", 32'(heartbeat), 0);
    tick();                            // wc4
    tick(); src_alive = 3'b100;        // wc5
    chk("norm_hb_wc5", 32'(heartbeat), 0);
    tick(); src_alive = 3'b000;        // wc6
    chk("norm_hb_pulse", 32'(heartbeat), 1);
    tick();                            // new window counter 1
    chk("norm_hb_single", 32'(heartbeat), 0);

    // 3. Timeout: only 011 in this window (also proves the window started clean)
    src_alive = 3'b011;
    tick(); src_alive = 3'b000;        // counter 2
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("to_no_hb", 32'(heartbeat), 0);
    end
    chk("to_missed_before", 32'(missed_src), 0);   // counter 7
    tick();
    chk("to_missed", 32'(missed_src), 3'b100);
    chk("to_hb_none", 32'(heartbeat), 0);
    src_alive = 3'b111;
    tick(); src_alive = 3'b000;
    chk("post_to_hb", 32'(heartbeat), 1);
    chk("post_to_missed", 32'(missed_src), 3'b100);
    tick();                            // counter 1
    chk("post_to_hb_low", 32'(heartbeat), 0);

    // 4. Completion on the last window cycle beats timeout
    src_alive = 3'b011;
    tick(); src_alive = 3'b000;        // counter 2
    for (int i = 0; i < 5; i++) tick(); // counter 7
    chk("last_hb_before", 32'(heartbeat), 0);
    src_alive = 3'b100;
    tick(); src_alive = 3'b111;
    chk("last_hb", 32'(heartbeat), 1);
    chk("last_missed", 32'(missed_src), 3'b100);

    // Back-to-back completions: heartbeat must alternate, never two in a row
    tick();
    chk("b2b_c1", 32'(heartbeat), 0);
    tick(); src_alive = 3'b000;
    chk("b2b_c2", 32'(heartbeat), 1);
    tick();
    chk("b2b_c3", 32'(heartbeat), 0);

    // 5. Recovery
    wd_force_reset = 1'b1;
    tick();                            // second force during RECOVER stays asserted
    chk("rec_state", 32'(state), 3);
    chk("rec_sys1", 32'(sys_reset), 1);
    chk("rec_count", 32'(reset_count), 1);
    chk("rec_hb", 32'(heartbeat), 0);
    chk("rec_en", 32'(wd_enable), 1);
    tick(); wd_force_reset = 1'b0;
    chk("rec_sys2", 32'(sys_reset), 1);
    chk("rec_count_nodup", 32'(reset_count), 1);
    tick();
    chk("rec_sys3", 32'(sys_reset), 1);
    chk("rec_state3", 32'(state), 3);
    tick();
    chk("rec_to_grace", 32'(state), 1);
    chk("rec_sys_drop", 32'(sys_reset), 0);
    chk("rec_grace_hb", 32'(heartbeat), 1);
    chk("rec_count_end", 32'(reset_count), 1);

    // 6a. arm=0 mid-RECOVER
    wd_force_reset = 1'b1;
    tick(); wd_force_reset = 1'b0;
    chk("abort_rec_state", 32'(state), 3);
    chk("abort_rec_count", 32'(reset_count), 2);
    arm = 1'b0;
    tick();
    chk("abort_state", 32'(state), 0);
    chk("abort_sys", 32'(sys_reset), 0);
    chk("abort_en", 32'(wd_enable), 0);
    chk("abort_count", 32'(reset_count), 2);
    chk("abort_missed", 32'(missed_src), 3'b100);
    wd_force_reset = 1'b1;
    tick(); wd_force_reset = 1'b0;
    chk("idle_ignore_force", 32'(state), 0);
    chk("idle_force_count", 32'(reset_count), 2);

    // 6b. rst mid-RECOVER
    arm = 1'b1;
    tick();
    chk("rearm_grace", 32'(state), 1);
    wd_force_reset = 1'b1;
    tick(); wd_force_reset = 1'b0;
    chk("rst_rec_state", 32'(state), 3);
    chk("rst_rec_count", 32'(reset_count), 3);
    rst = 1'b1;
    tick();
    chk("rst_abort_state", 32'(state), 0);
    chk("rst_abort_sys", 32'(sys_reset), 0);
    chk("rst_abort_en", 32'(wd_enable), 0);
    chk("rst_abort_count", 32'(reset_count), 0);
    chk("rst_abort_missed", 32'(missed_src), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
